// File: rtl/gpreg_pkg.sv
// Shared widths, command encodings and write payload for the GP register file access controller.
package gpreg_pkg;

  localparam int unsigned NREG   = 8;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned DW     = 32;

  localparam logic [1:0] GP_IDLE  = 2'b00;
  localparam logic [1:0] GP_READ  = 2'b01;
  localparam logic [1:0] GP_WRITE = 2'b11;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DW-1:0]     data;
  } gp_wr_t;

  // One-hot mask for a register address, used by the scoreboard update.
  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    return NREG'(1) << a;
  endfunction

endpackage

// File: rtl/gpreg_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves past the winner when advance is high.
module gpreg_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant_c
);

  logic ptr;

  // ptr=0 favours requester 0 on a tie, ptr=1 favours requester 1.
  always_comb begin
    grant_c = req;
    if (req == 2'b11) begin
      grant_c = ptr ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= grant_c[0];
    end
  end

endmodule

// File: rtl/gpreg_access_ctrl.sv
// Sequences register-file commands from two write ports and one read port with a pending-write scoreboard.
// Optional performance counters are enabled with GPREG_ACCESS_CTRL_PERF_EN.
module gpreg_access_ctrl
  import gpreg_pkg::*;
#(
  parameter int unsigned RD_STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb0_valid,
  output logic              wb0_ready,
  input  logic [REG_AW-1:0] wb0_addr,
  input  logic [DW-1:0]     wb0_data,
  input  logic              wb1_valid,
  output logic              wb1_ready,
  input  logic [REG_AW-1:0] wb1_addr,
  input  logic [DW-1:0]     wb1_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [REG_AW-1:0] rd_x,
  input  logic [REG_AW-1:0] rd_y,
  output logic              rd_done,
  input  logic              rsv_valid,
  output logic              rsv_ready,
  input  logic [REG_AW-1:0] rsv_addr,
  output logic [REG_AW-1:0] SelX,
  output logic [REG_AW-1:0] SelY,
  output logic [REG_AW-1:0] SelZ,
  output logic [1:0]        MemInstruction,
  output logic [DW-1:0]     MemData,
`ifdef GPREG_ACCESS_CTRL_PERF_EN
  output logic [15:0]       hazard_stall_cnt,
  output logic [15:0]       port_conflict_cnt,
`endif
  output logic [NREG-1:0]   pending
);

  localparam int unsigned SW = $clog2(RD_STARVE_MAX + 1);

  logic [SW-1:0]     starve, starve_nxt;
  logic [NREG-1:0]   pending_nxt;
  logic [1:0]        grant_c;
  logic              rd_hazard, rd_elig, rd_win;
  logic              wb0_xfer, wb1_xfer, wr_xfer, rd_xfer, rsv_xfer;
  gp_wr_t            wr_sel;
  logic [REG_AW-1:0] sel_x_nxt, sel_y_nxt, sel_z_nxt;
  logic [1:0]        mi_nxt;
  logic [DW-1:0]     data_nxt;

  gpreg_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({wb1_valid, wb0_valid}),
    .advance (wr_xfer),
    .grant_c (grant_c)
  );

  // Grant selection: a hazard-free read wins only when no write is waiting or it has starved long enough.
  always_comb begin
    rd_hazard = pending[rd_x] | pending[rd_y];
    rd_elig   = rd_valid & ~rd_hazard;
    rd_win    = rd_elig & ((starve == SW'(RD_STARVE_MAX)) | ~(wb0_valid | wb1_valid));
    rd_ready  = rd_win;
    wb0_ready = grant_c[0] & ~rd_win;
    wb1_ready = grant_c[1] & ~rd_win;
    rsv_ready = ~pending[rsv_addr];
    wb0_xfer  = wb0_valid & wb0_ready;
    wb1_xfer  = wb1_valid & wb1_ready;
    wr_xfer   = wb0_xfer | wb1_xfer;
    rd_xfer   = rd_valid & rd_ready;
    rsv_xfer  = rsv_valid & rsv_ready;
    wr_sel    = wb0_xfer ? gp_wr_t'{addr: wb0_addr, data: wb0_data}
                         : gp_wr_t'{addr: wb1_addr, data: wb1_data};
  end

  // Scoreboard: the write clear is applied before the reservation so a same-edge reserve wins.
  always_comb begin
    pending_nxt = pending;
    if (wr_xfer) begin
      pending_nxt = pending_nxt & ~reg_onehot(wr_sel.addr);
    end
    if (rsv_xfer) begin
      pending_nxt = pending_nxt | reg_onehot(rsv_addr);
    end
  end

  always_comb begin
    starve_nxt = starve;
    if (rd_xfer || !rd_elig) begin
      starve_nxt = '0;
    end else if (wr_xfer && (starve != SW'(RD_STARVE_MAX))) begin
      starve_nxt = starve + SW'(1);
    end
  end

  // Next register-file command; selects and data hold when idle.
  always_comb begin
    mi_nxt    = GP_IDLE;
    sel_x_nxt = SelX;
    sel_y_nxt = SelY;
    sel_z_nxt = SelZ;
    data_nxt  = MemData;
    if (wr_xfer) begin
      mi_nxt    = GP_WRITE;
      sel_z_nxt = wr_sel.addr;
      data_nxt  = wr_sel.data;
    end else if (rd_xfer) begin
      mi_nxt    = GP_READ;
      sel_x_nxt = rd_x;
      sel_y_nxt = rd_y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SelX           <= '0;
      SelY           <= '0;
      SelZ           <= '0;
      MemInstruction <= GP_IDLE;
      MemData        <= '0;
      pending        <= '0;
      rd_done        <= 1'b0;
      starve         <= '0;
    end else begin
      SelX           <= sel_x_nxt;
      SelY           <= sel_y_nxt;
      SelZ           <= sel_z_nxt;
      MemInstruction <= mi_nxt;
      MemData        <= data_nxt;
      pending        <= pending_nxt;
      rd_done        <= (MemInstruction == GP_READ);
      starve         <= starve_nxt;
    end
  end

`ifdef GPREG_ACCESS_CTRL_PERF_EN
  // Saturating event counters for read hazard stalls and write-port contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hazard_stall_cnt  <= '0;
      port_conflict_cnt <= '0;
    end else begin
      if (rd_valid && rd_hazard && (hazard_stall_cnt != 16'hFFFF)) begin
        hazard_stall_cnt <= hazard_stall_cnt + 16'd1;
      end
      if (wb0_valid && wb1_valid && (port_conflict_cnt != 16'hFFFF)) begin
        port_conflict_cnt <= port_conflict_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gpreg_access_ctrl.sv
// Directed self-checking bench for gpreg_access_ctrl.
module tb_gpreg_access_ctrl;

  logic        clk, rst;
  logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [2:0]  wb0_addr, wb1_addr;
  logic [31:0] wb0_data, wb1_data;
  logic        rd_valid, rd_ready, rd_done;
  logic [2:0]  rd_x, rd_y;
  logic        rsv_valid, rsv_ready;
  logic [2:0]  rsv_addr;
  logic [2:0]  SelX, SelY, SelZ;
  logic [1:0]  MemInstruction;
  logic [31:0] MemData;
  logic [7:0]  pending;
`ifdef GPREG_ACCESS_CTRL_PERF_EN
  logic [15:0] hazard_stall_cnt, port_conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  gpreg_access_ctrl dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_x(rd_x), .rd_y(rd_y), .rd_done(rd_done),
    .rsv_valid(rsv_valid), .rsv_ready(rsv_ready), .rsv_addr(rsv_addr),
    .SelX(SelX), .SelY(SelY), .SelZ(SelZ), .MemInstruction(MemInstruction), .MemData(MemData),
`ifdef GPREG_ACCESS_CTRL_PERF_EN
    .hazard_stall_cnt(hazard_stall_cnt), .port_conflict_cnt(port_conflict_cnt),
`endif
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic [31:0] vals[3];
  int n0, n1;

  initial begin
    wb0_valid = 0; wb0_addr = 0; wb0_data = 0;
    wb1_valid = 0; wb1_addr = 0; wb1_data = 0;
    rd_valid = 0; rd_x = 0; rd_y = 0;
    rsv_valid = 0; rsv_addr = 0;
    apply_reset();

    // Reset state
    check("rst_mi", 32'(MemInstruction), 32'd0);
    check("rst_selz", 32'(SelZ), 32'd0);
    check("rst_data", MemData, 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_rd_done", 32'(rd_done), 32'd0);

    // Back-to-back wb0 writes
    vals[0] = 32'd55; vals[1] = 32'd44; vals[2] = 32'd37;
    for (int i = 0; i < 3; i++) begin
      wb0_valid = 1; wb0_addr = 3'(i); wb0_data = vals[i];
      #1;
      check("b2b_ready", 32'(wb0_ready), 32'd1);
      tick();
      check("b2b_mi", 32'(MemInstruction), 32'd3);
      check("b2b_selz", 32'(SelZ), 32'(i));
      check("b2b_data", MemData, vals[i]);
    end
    wb0_valid = 0;
    tick();
    check("idle_mi", 32'(MemInstruction), 32'd0);
    check("idle_selz_hold", 32'(SelZ), 32'd2);
    check("idle_data_hold", MemData, 32'd37);

    // Round-robin between wb0 and wb1 from a fresh reset
    apply_reset();
    n0 = 0; n1 = 0;
    wb0_valid = 1; wb0_addr = 3; wb1_valid = 1; wb1_addr = 4;
    for (int i = 0; i < 4; i++) begin
      wb0_data = 32'(10 + n0); wb1_data = 32'(20 + n1);
      #1;
      check("rr_wb0_ready", 32'(wb0_ready), 32'((i % 2) == 0));
      check("rr_wb1_ready", 32'(wb1_ready), 32'((i % 2) == 1));
      tick();
      check("rr_selz", 32'(SelZ), (i % 2 == 0) ? 32'd3 : 32'd4);
      check("rr_data", MemData, (i % 2 == 0) ? 32'(10 + n0) : 32'(20 + n1));
      if (i % 2 == 0) n0++; else n1++;
    end
    wb0_valid = 0; wb1_valid = 0;

    // Reserve R1, read blocked until wb1 writes R1
    rsv_valid = 1; rsv_addr = 1;
    #1;
    check("rsv1_ready", 32'(rsv_ready), 32'd1);
    tick();
    rsv_valid = 0;
    check("rsv1_pending", 32'(pending), 32'h02);
    rd_valid = 1; rd_x = 1; rd_y = 2;
    #1;
    check("haz_rd_ready", 32'(rd_ready), 32'd0);
    wb1_valid = 1; wb1_addr = 1; wb1_data = 32'd99;
    #1;
    check("haz_wb1_ready", 32'(wb1_ready), 32'd1);
    check("haz_rd_ready2", 32'(rd_ready), 32'd0);
    tick();
    wb1_valid = 0;
    check("haz_wr_mi", 32'(MemInstruction), 32'd3);
    check("haz_wr_data", MemData, 32'd99);
    check("haz_cleared", 32'(pending), 32'd0);
    #1;
    check("haz_rd_go", 32'(rd_ready), 32'd1);
    tick();
    rd_valid = 0;
    check("rd_mi", 32'(MemInstruction), 32'd1);
    check("rd_selx", 32'(SelX), 32'd1);
    check("rd_sely", 32'(SelY), 32'd2);
    check("rd_done_early", 32'(rd_done), 32'd0);
    tick();
    check("rd_done_pulse", 32'(rd_done), 32'd1);
    check("rd_after_mi", 32'(MemInstruction), 32'd0);
    tick();
    check("rd_done_low", 32'(rd_done), 32'd0);

    // Starvation limit: read forced through on the 5th cycle
    wb0_valid = 1; wb0_addr = 6; wb0_data = 32'h66;
    rd_valid = 1; rd_x = 3; rd_y = 4;
    for (int c = 1; c <= 6; c++) begin
      #1;
      check("stv_rd_ready", 32'(rd_ready), 32'(c == 5));
      check("stv_wb0_ready", 32'(wb0_ready), 32'(c != 5));
      tick();
      check("stv_mi", 32'(MemInstruction), (c == 5) ? 32'd1 : 32'd3);
      if (c == 5) rd_valid = 0;
    end
    check("stv_pending", 32'(pending), 32'd0);

    // Same-edge reserve and write to R5: reservation wins
    wb0_addr = 5; wb0_data = 32'd7;
    rsv_valid = 1; rsv_addr = 5;
    #1;
    check("conf_rsv_ready", 32'(rsv_ready), 32'd1);
    check("conf_wb0_ready", 32'(wb0_ready), 32'd1);
    tick();
    wb0_valid = 0;
    check("conf_pending", 32'(pending), 32'h20);
    #1;
    check("conf_rsv_again", 32'(rsv_ready), 32'd0);
    rsv_valid = 0;

    // Asynchronous reset mid-stream
    wb0_valid = 1; wb0_addr = 2; wb0_data = 32'd5;
    rd_valid = 1; rd_x = 5; rd_y = 0;
    #1;
    check("mid_rd_blocked", 32'(rd_ready), 32'd0);
    tick();
    check("mid_mi", 32'(MemInstruction), 32'd3);
    #2;
    rst = 1;
    #1;
    check("arst_mi", 32'(MemInstruction), 32'd0);
    check("arst_selz", 32'(SelZ), 32'd0);
    check("arst_data", MemData, 32'd0);
    check("arst_pending", 32'(pending), 32'd0);
    wb0_valid = 0; rd_valid = 0;
    @(negedge clk);
    rst = 0;
    tick();
    check("post_rst_mi", 32'(MemInstruction), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
